fifo_wr_arbiter: RTL

Write-side arbiter for the asynchronous FIFO, in the write clock domain. Shares the single FIFO write port among `NUM_REQ` requesters using round-robin arbitration with burst locking. It drives the write-pointer handler's enable and the FIFO memory write data, and it honours the handler's registered full flag.

---
 rtl/fifo_wr_arbiter_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_rr.sv | 38 +++
 rtl/fifo_wr_arbiter.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared constants for the FIFO write-side arbiter.
//   ST_IDLE / ST_BURST : FSM state encoding (1-bit, legacy-compatible constants)
//   idx_w(n)           : width of a requester index for n requesters
//   cnt_w(mb)          : width of a beat counter able to hold 0..mb
package fifo_arb_pkg;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   localparam int NUM_REQ_DEF    = 4;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int MAX_BURST_DEF  = 8;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int cnt_w(input int mb);
      return (mb > 0) ? $clog2(mb + 1) : 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick starting one past the last winner.
//   i_req      : request vector
//   i_last_idx : index of the previous winner (search starts at i_last_idx+1)
//   o_gnt      : one-hot winner (0 when no request)
//   o_idx      : winner index
//   o_vld      : any request present
module rr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   localparam int IW     = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IW-1:0]      i_last_idx,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IW-1:0]      o_idx,
   output logic               o_vld
);

   int cand;

   // Walk NUM_REQ candidates in increasing index from last+1, wrapping; first hit wins.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_vld = 1'b0;
      cand  = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(i_last_idx) + k) % NUM_REQ;
         if (!o_vld && i_req[cand]) begin
            o_vld       = 1'b1;
            o_gnt[cand] = 1'b1;
            o_idx       = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-locked sharing of the async FIFO write port.
//   i_clk, i_rstn : write-domain clock, asynchronous active-low reset
//   i_req/i_data/i_last/o_ack : per-requester valid, word, last-beat, ready
//   i_full        : registered full flag from the write-pointer handler
//   o_wr_en/o_wr_data : write enable and data toward pointer handler / FIFO memory
//   o_grant/o_gnt_idx : registered one-hot grant and current/last grantee index
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = NUM_REQ_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int MAX_BURST  = MAX_BURST_DEF
) (
   input  logic                          i_clk,
   input  logic                          i_rstn,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
   input  logic [NUM_REQ-1:0]            i_last,
   output logic [NUM_REQ-1:0]            o_ack,
   input  logic                          i_full,
   output logic                          o_wr_en,
   output logic [DATA_WIDTH-1:0]         o_wr_data,
   output logic [NUM_REQ-1:0]            o_grant,
   output logic [$clog2(NUM_REQ)-1:0]    o_gnt_idx
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int CW = cnt_w(MAX_BURST);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BURST);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

   logic [0:0]         state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]      gnt_idx_q, gnt_idx_d;
   logic [IW-1:0]      last_q, last_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   logic [NUM_REQ-1:0] win_gnt;
   logic [IW-1:0]      win_idx;
   logic               win_vld;

   logic               in_burst;
   logic               req_g;
   logic               last_g;
   logic               xfer;
   logic               burst_end;
   logic [CW-1:0]      cnt_inc;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .i_req      (i_req),
      .i_last_idx (last_q),
      .o_gnt      (win_gnt),
      .o_idx      (win_idx),
      .o_vld      (win_vld)
   );

   // Datapath and handshake: everything is gated by BURST so IDLE (and reset) drive zeros.
   // The transfer term uses the same i_full the pointer handler gates with, so a beat
   // the handler would drop is never counted here.
   always_comb begin
      in_burst  = (state_q == ST_BURST);
      req_g     = i_req[gnt_idx_q];
      last_g    = i_last[gnt_idx_q];
      xfer      = in_burst & req_g & ~i_full;
      cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      // A dropped request ends the burst even while full; otherwise full holds position.
      burst_end = in_burst & (~req_g | (xfer & (last_g | (cnt_inc == CNT_MAX))));
      o_ack     = (in_burst & ~i_full) ? grant_q : '0;
      o_wr_en   = xfer;
      o_wr_data = in_burst ? i_data[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
      o_grant   = grant_q;
      o_gnt_idx = gnt_idx_q;
   end

   // FSM / grant / beat counter next state. Every burst exit lands in IDLE, which
   // yields the one-cycle arbitration bubble between grants.
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      gnt_idx_d = gnt_idx_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      if (!in_burst) begin
         if (win_vld) begin
            state_d   = ST_BURST;
            grant_d   = win_gnt;
            gnt_idx_d = win_idx;
            last_d    = win_idx;
            cnt_d     = '0;
         end
      end else begin
         cnt_d = xfer ? cnt_inc : cnt_q;
         if (burst_end) begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      end
   end

   // last resets to NUM_REQ-1 so requester 0 is searched first after reset.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         gnt_idx_q <= '0;
         last_q    <= IDX_LAST;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         gnt_idx_q <= gnt_idx_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

endmodule
